// File: rtl/row_sched_pkg.sv
// row_sched_pkg: shared constants and the controller state encoding for the
// row scheduler that sequences the three-line window buffer feeding the 3x3
// row kernel.
//   ROWS         - rows per frame
//   ROW_W        - width of row indices and frame-memory addresses
//   LINE_W       - pixels per line (informational, shared with the line buffer)
//   PRIME_CYCLES - line-buffer fill steps issued at row 0 before the first window
//   LAST_ROW     - ROWS-1 at ROW_W bits, the row that ends a frame
package row_sched_pkg;

    localparam int ROWS         = 720;
    localparam int ROW_W        = 10;
    localparam int LINE_W       = 1280;
    localparam int PRIME_CYCLES = 3;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_ISSUE,
        ST_WAIT_KERNEL,
        ST_SETTLE,
        ST_ADVANCE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/row_scheduler_valid_delay.sv
// valid_delay: DEPTH-stage single-bit shift register with asynchronous
// active-low clear. Used to turn a host read grant into the matching read-data
// valid strobe once the frame memory latency has elapsed.
//   clk   - clock, shifts on rising edge
//   rst_n - asynchronous active-low clear of every stage
//   din   - bit entering the line
//   dout  - din delayed by exactly DEPTH cycles
module valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stage_reg;
    logic [DEPTH-1:0] stage_next;

    assign stage_next[0] = din;

    // Each stage takes the one before it; DEPTH=1 leaves this loop empty.
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
        assign stage_next[gi] = stage_reg[gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/row_scheduler.sv
// row_scheduler: frame-level controller for the three-line window buffer.
// Primes the line buffer at row 0, then for every row waits for a valid window,
// hands it to the kernel (row_start / kernel_done), lets the memory settle and
// steps the window down one row. Also arbitrates the single frame-memory read
// port between line-buffer fetches and a host reader; the host only gets the
// port while the window is idle (IDLE, WAIT_KERNEL, DONE).
// Ports:
//   clk, rst_n       - clock and asynchronous active-low reset
//   start            - frame start pulse, honoured only in IDLE
//   busy             - high in every state except IDLE
//   frame_done       - one-cycle pulse after the last row's kernel_done
//   calc_row         - current row index to the line buffer
//   lb_step          - line-buffer advance enable
//   lb_valid         - line-buffer window valid
//   lb_fetch_addr    - memory row requested by the line buffer
//   row_start        - one-cycle pulse: window for calc_row is valid
//   kernel_done      - kernel finished the current row
//   host_req/addr    - host read request (held until granted) and its row
//   host_gnt         - host read accepted this cycle
//   host_rvalid      - host read data valid at the memory output
//   mem_addr         - frame-memory read address
module row_scheduler
    import row_sched_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    output logic [ROW_W-1:0] calc_row,
    output logic             lb_step,
    input  logic             lb_valid,
    input  logic [ROW_W-1:0] lb_fetch_addr,
    output logic             row_start,
    input  logic             kernel_done,
    input  logic             host_req,
    input  logic [ROW_W-1:0] host_addr,
    output logic             host_gnt,
    output logic             host_rvalid,
    output logic [ROW_W-1:0] mem_addr
);

    // One counter serves both the PRIME fill and the SETTLE wait.
    localparam int CNT_MAX = (PRIME_CYCLES > MEM_LAT) ? PRIME_CYCLES : MEM_LAT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PRIME_LAST  = CNT_W'(PRIME_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(MEM_LAT - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] step_cnt_reg;
    logic [ROW_W-1:0] calc_row_reg;
    logic             busy_reg;
    logic             lb_step_reg;
    logic             frame_done_reg;
    logic             host_window;

    // busy, lb_step and frame_done are loaded together with the state they
    // belong to, so they are plain flops aligned with state_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            step_cnt_reg   <= '0;
            calc_row_reg   <= '0;
            busy_reg       <= 1'b0;
            lb_step_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            lb_step_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_PRIME;
                        step_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                        lb_step_reg  <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    if (step_cnt_reg == PRIME_LAST) begin
                        state_reg <= ST_ISSUE;
                    end else begin
                        step_cnt_reg <= step_cnt_reg + 1'b1;
                        lb_step_reg  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (lb_valid) begin
                        state_reg <= ST_WAIT_KERNEL;
                    end
                end
                ST_WAIT_KERNEL: begin
                    if (kernel_done) begin
                        if (calc_row_reg == LAST_ROW) begin
                            state_reg      <= ST_DONE;
                            frame_done_reg <= 1'b1;
                        end else begin
                            state_reg    <= ST_SETTLE;
                            step_cnt_reg <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (step_cnt_reg == SETTLE_LAST) begin
                        state_reg   <= ST_ADVANCE;
                        lb_step_reg <= 1'b1;
                    end else begin
                        step_cnt_reg <= step_cnt_reg + 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    // Only reached from rows below LAST_ROW, so no wrap.
                    calc_row_reg <= calc_row_reg + 1'b1;
                    state_reg    <= ST_ISSUE;
                end
                ST_DONE: begin
                    calc_row_reg <= '0;
                    busy_reg     <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // The window is handed over in the same cycle the line buffer reports it.
    assign row_start = (state_reg == ST_ISSUE) && lb_valid;

    // Host owns the port only while the line buffer is not fetching; rst_n is
    // included so no grant can appear while reset is held.
    assign host_window = (state_reg == ST_IDLE) || (state_reg == ST_WAIT_KERNEL) ||
                         (state_reg == ST_DONE);
    assign host_gnt    = host_req && host_window && rst_n;
    assign mem_addr    = host_gnt ? host_addr : lb_fetch_addr;

    valid_delay #(
        .DEPTH (MEM_LAT)
    ) u_rvalid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (host_gnt),
        .dout  (host_rvalid)
    );

    assign busy       = busy_reg;
    assign lb_step    = lb_step_reg;
    assign frame_done = frame_done_reg;
    assign calc_row   = calc_row_reg;

endmodule
